// File: rtl/s32x_sdr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | s32x_sdr_arbiter: round-robin N-master arbiter with timeout for 32X SDRAM  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module s32x_sdr_arbiter #(
  parameter int NUM_M   = 2,
  parameter int AW      = 17,
  parameter int DW      = 16,
  parameter int TIMEOUT = 0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_M-1:0]         M_REQ,
  input  logic [NUM_M-1:0]         M_WR,
  input  logic [NUM_M*DW/8-1:0]    M_BE,
  input  logic [NUM_M*AW-1:0]      M_A,
  input  logic [NUM_M*DW-1:0]      M_WDATA,
  output logic [NUM_M-1:0]         M_ACK,
  output logic [NUM_M-1:0]         M_WAIT,
  output logic [DW-1:0]            M_RDATA,
  output logic                     SDR_REQ,
  output logic                     SDR_WR,
  output logic [DW/8-1:0]          SDR_BE,
  output logic [AW-1:0]            SDR_A,
  output logic [DW-1:0]            SDR_WDATA,
  input  logic                     SDR_ACK,
  input  logic [DW-1:0]            SDR_RDATA,
  output logic                     ERR,
  output logic [$clog2(NUM_M)-1:0] GNT_ID
);

  localparam int BW = DW / 8;
  localparam int GW = $clog2(NUM_M);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [GW-1:0]   r_ptr;
  logic [GW-1:0]   r_gnt;
  logic [NUM_M-1:0] r_ack;
  logic [DW-1:0]   r_rdata;
  logic            r_err;
  logic            r_sdr_req;
  logic            r_sdr_wr;
  logic [BW-1:0]   r_sdr_be;
  logic [AW-1:0]   r_sdr_a;
  logic [DW-1:0]   r_sdr_wdata;

  logic [GW:0]     w_sum;
  logic [GW-1:0]   w_pick;
  logic            w_found;
  logic            w_sel_wr;
  logic [BW-1:0]   w_sel_be;
  logic [AW-1:0]   w_sel_a;
  logic [DW-1:0]   w_sel_wd;
  logic            w_expire;
  logic            w_fin;

  // Scan offsets from highest to lowest so the requester closest to r_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int k = NUM_M - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (GW+1)'(k);
      if (w_sum >= (GW+1)'(NUM_M)) begin
        w_sum = w_sum - (GW+1)'(NUM_M);
      end
      if (M_REQ[w_sum[GW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[GW-1:0];
      end
    end
  end

  always_comb begin
    w_sel_wr = 1'b0;
    w_sel_be = '0;
    w_sel_a  = '0;
    w_sel_wd = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (w_pick == GW'(i)) begin
        w_sel_wr = M_WR[i];
        w_sel_be = M_BE[i*BW +: BW];
        w_sel_a  = M_A[i*AW +: AW];
        w_sel_wd = M_WDATA[i*DW +: DW];
      end
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] r_tcnt;
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          r_tcnt <= '0;
        end else if (r_state == S_IDLE) begin
          r_tcnt <= '0;
        end else if ((r_state == S_BUSY) && (r_tcnt != CW'(TIMEOUT))) begin
          r_tcnt <= r_tcnt + CW'(1);
        end
      end
      assign w_expire = (r_state == S_BUSY) && (r_tcnt == CW'(TIMEOUT));
    end else begin : g_no_timeout
      assign w_expire = 1'b0;
    end
  endgenerate

  assign w_fin = (r_state == S_BUSY) && (SDR_ACK || w_expire);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_fin)   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_ack       <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_sdr_req   <= 1'b0;
      r_sdr_wr    <= 1'b0;
      r_sdr_be    <= '0;
      r_sdr_a     <= '0;
      r_sdr_wdata <= '0;
    end else begin
      r_ack <= '0;
      if ((r_state == S_IDLE) && w_found) begin
        r_gnt       <= w_pick;
        r_sdr_req   <= 1'b1;
        r_sdr_wr    <= w_sel_wr;
        r_sdr_be    <= w_sel_be;
        r_sdr_a     <= w_sel_a;
        r_sdr_wdata <= w_sel_wd;
      end
      if (w_fin) begin
        r_sdr_req <= 1'b0;
        r_ack     <= NUM_M'(1) << r_gnt;
        r_ptr     <= (r_gnt == GW'(NUM_M - 1)) ? '0 : r_gnt + GW'(1);
        // A real ack takes priority over a timeout expiring in the same cycle.
        if (SDR_ACK) begin
          if (!r_sdr_wr) begin
            r_rdata <= SDR_RDATA;
          end
        end else begin
          r_rdata <= '1;
          r_err   <= 1'b1;
        end
      end
    end
  end

  assign M_ACK     = r_ack;
  assign M_WAIT    = M_REQ & ~r_ack;
  assign M_RDATA   = r_rdata;
  assign SDR_REQ   = r_sdr_req;
  assign SDR_WR    = r_sdr_wr;
  assign SDR_BE    = r_sdr_be;
  assign SDR_A     = r_sdr_a;
  assign SDR_WDATA = r_sdr_wdata;
  assign ERR       = r_err;
  assign GNT_ID    = r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_s32x_sdr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_s32x_sdr_arbiter: directed scoreboard bench for s32x_sdr_arbiter        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_s32x_sdr_arbiter;

  localparam int NUM_M   = 2;
  localparam int AW      = 17;
  localparam int DW      = 16;
  localparam int TIMEOUT = 8;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NUM_M-1:0]  M_REQ;
  logic [NUM_M-1:0]  M_WR;
  logic [NUM_M*2-1:0] M_BE;
  logic [NUM_M*AW-1:0] M_A;
  logic [NUM_M*DW-1:0] M_WDATA;
  logic [NUM_M-1:0]  M_ACK;
  logic [NUM_M-1:0]  M_WAIT;
  logic [DW-1:0]     M_RDATA;
  logic              SDR_REQ;
  logic              SDR_WR;
  logic [1:0]        SDR_BE;
  logic [AW-1:0]     SDR_A;
  logic [DW-1:0]     SDR_WDATA;
  logic              SDR_ACK;
  logic [DW-1:0]     SDR_RDATA;
  logic              ERR;
  logic [0:0]        GNT_ID;

  s32x_sdr_arbiter #(
    .NUM_M(NUM_M), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .RST(RST),
    .M_REQ(M_REQ), .M_WR(M_WR), .M_BE(M_BE), .M_A(M_A), .M_WDATA(M_WDATA),
    .M_ACK(M_ACK), .M_WAIT(M_WAIT), .M_RDATA(M_RDATA),
    .SDR_REQ(SDR_REQ), .SDR_WR(SDR_WR), .SDR_BE(SDR_BE), .SDR_A(SDR_A),
    .SDR_WDATA(SDR_WDATA), .SDR_ACK(SDR_ACK), .SDR_RDATA(SDR_RDATA),
    .ERR(ERR), .GNT_ID(GNT_ID)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          id;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_master(input int i, input logic wr, input logic [1:0] be,
                            input logic [16:0] a, input logic [15:0] wd);
    M_WR[i]            = wr;
    M_BE[i*2 +: 2]     = be;
    M_A[i*AW +: AW]    = a;
    M_WDATA[i*DW +: DW] = wd;
  endtask

  task automatic wait_sdr_req(input string tag);
    for (int c = 0; c < 20 && !SDR_REQ; c++) tick();
    check(tag, 32'(SDR_REQ), 32'd1);
  endtask

  // Pops the oldest expected completion and compares it with the ack cycle.
  task automatic sb_check(input string tag);
    exp_t e;
    logic [1:0] m;
    check({tag, "_sb_pending"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    m = 2'(1 << e.id);
    check({tag, "_ack"},   32'(M_ACK),   32'(m));
    check({tag, "_rdata"}, 32'(M_RDATA), 32'(e.rdata));
    check({tag, "_err"},   32'(ERR),     32'(e.err));
  endtask

  initial begin
    RST = 1'b1; M_REQ = '0; M_WR = '0; M_BE = '0; M_A = '0; M_WDATA = '0;
    SDR_ACK = 1'b0; SDR_RDATA = '0;
    tick(); tick();
    check("rst_ack",   32'(M_ACK),   32'd0);
    check("rst_req",   32'(SDR_REQ), 32'd0);
    check("rst_rdata", 32'(M_RDATA), 32'd0);
    check("rst_err",   32'(ERR),     32'd0);
    check("rst_gnt",   32'(GNT_ID),  32'd0);
    check("rst_wait",  32'(M_WAIT),  32'd0);
    RST = 1'b0;
    tick();

    // Single read, ack three cycles after grant
    set_master(0, 1'b0, 2'b11, 17'h01234, 16'h0000);
    M_REQ = 2'b01;
    sb.push_back('{0, 16'hBEEF, 1'b0});
    tick();
    check("t1_req_c1",  32'(SDR_REQ), 32'd1);
    check("t1_addr",    32'(SDR_A),   32'h1234);
    check("t1_wait",    32'(M_WAIT),  32'h1);
    tick();
    check("t1_req_c2",  32'(SDR_REQ), 32'd1);
    tick();
    check("t1_req_c3",  32'(SDR_REQ), 32'd1);
    check("t1_noack_c3", 32'(M_ACK),  32'd0);
    SDR_ACK = 1'b1; SDR_RDATA = 16'hBEEF;
    tick();
    SDR_ACK = 1'b0;
    sb_check("t1");
    check("t1_req_drop", 32'(SDR_REQ), 32'd0);
    M_REQ = 2'b00;
    tick();
    check("t1_ack_pulse", 32'(M_ACK), 32'd0);

    // Byte write from master 1; read data must stay untouched
    set_master(1, 1'b1, 2'b10, 17'h00055, 16'hAB00);
    M_REQ = 2'b10;
    sb.push_back('{1, 16'hBEEF, 1'b0});
    wait_sdr_req("t3_req");
    check("t3_wr",    32'(SDR_WR),    32'd1);
    check("t3_be",    32'(SDR_BE),    32'h2);
    check("t3_wdata", 32'(SDR_WDATA), 32'hAB00);
    check("t3_addr",  32'(SDR_A),     32'h55);
    check("t3_gnt",   32'(GNT_ID),    32'd1);
    SDR_ACK = 1'b1; SDR_RDATA = 16'h5A5A;
    tick();
    SDR_ACK = 1'b0;
    sb_check("t3");
    M_REQ = 2'b00;
    tick();

    // Contention with zero-wait SDRAM: grants alternate 0,1,0,1
    set_master(0, 1'b0, 2'b11, 17'h00100, 16'h0000);
    set_master(1, 1'b0, 2'b11, 17'h00200, 16'h0000);
    M_REQ = 2'b11;
    for (int n = 0; n < 4; n++) begin
      int id;
      id = n % 2;
      sb.push_back('{id, 16'(16'h1000 + n), 1'b0});
      wait_sdr_req("t2_req");
      check("t2_gnt",       32'(GNT_ID), 32'(id));
      check("t2_wait_busy", 32'(M_WAIT), 32'h3);
      SDR_ACK = 1'b1; SDR_RDATA = 16'(16'h1000 + n);
      tick();
      SDR_ACK = 1'b0;
      sb_check("t2");
      check("t2_wait_done", 32'(M_WAIT), 32'(2'b11 & ~2'(1 << id)));
      if (n == 3) M_REQ = 2'b00;
      tick();
    end

    // Ack arrives on the exact timeout expiry cycle: ack wins
    set_master(0, 1'b0, 2'b11, 17'h00300, 16'h0000);
    M_REQ = 2'b01;
    sb.push_back('{0, 16'h7777, 1'b0});
    for (int c = 1; c <= 9; c++) tick();
    check("t5_noack_c9", 32'(M_ACK),   32'd0);
    check("t5_req_c9",   32'(SDR_REQ), 32'd1);
    SDR_ACK = 1'b1; SDR_RDATA = 16'h7777;
    tick();
    SDR_ACK = 1'b0;
    sb_check("t5");
    M_REQ = 2'b00;
    tick();

    // Timeout: ack never arrives
    set_master(0, 1'b0, 2'b11, 17'h00400, 16'h0000);
    M_REQ = 2'b01;
    sb.push_back('{0, 16'hFFFF, 1'b1});
    for (int c = 1; c <= 9; c++) tick();
    check("t4_noack_c9", 32'(M_ACK), 32'd0);
    check("t4_noerr_c9", 32'(ERR),   32'd0);
    tick();
    sb_check("t4");
    check("t4_req_drop", 32'(SDR_REQ), 32'd0);
    M_REQ = 2'b00;
    tick(); tick();
    check("t4_err_sticky", 32'(ERR), 32'd1);
    M_REQ = 2'b01;
    sb.push_back('{0, 16'h2222, 1'b1});
    wait_sdr_req("t4b_req");
    SDR_ACK = 1'b1; SDR_RDATA = 16'h2222;
    tick();
    SDR_ACK = 1'b0;
    sb_check("t4b");
    M_REQ = 2'b00;
    tick();

    // Reset in the middle of an access; pointer restarts at 0 afterwards
    M_REQ = 2'b01;
    wait_sdr_req("t6_req");
    RST = 1'b1;
    #1;
    check("t6_req_async",   32'(SDR_REQ), 32'd0);
    check("t6_err_async",   32'(ERR),     32'd0);
    check("t6_rdata_async", 32'(M_RDATA), 32'd0);
    check("t6_gnt_async",   32'(GNT_ID),  32'd0);
    check("t6_ack_async",   32'(M_ACK),   32'd0);
    check("t6_addr_async",  32'(SDR_A),   32'd0);
    M_REQ = 2'b11;
    tick(); tick();
    RST = 1'b0;
    sb.push_back('{0, 16'h3333, 1'b0});
    sb.push_back('{1, 16'h4444, 1'b0});
    wait_sdr_req("t6_req0");
    check("t6_gnt0", 32'(GNT_ID), 32'd0);
    SDR_ACK = 1'b1; SDR_RDATA = 16'h3333;
    tick();
    SDR_ACK = 1'b0;
    sb_check("t6a");
    M_REQ = 2'b10;
    tick();
    wait_sdr_req("t6_req1");
    check("t6_gnt1", 32'(GNT_ID), 32'd1);
    SDR_ACK = 1'b1; SDR_RDATA = 16'h4444;
    tick();
    SDR_ACK = 1'b0;
    sb_check("t6b");
    M_REQ = 2'b00;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
